// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg
// ----------------------------------------------------------------------------
// Shared CPU definitions: MIPS opcode/funct constants, the "no exception"
// code, and the is_branch() classifier. The classifier is also used by the
// decode and exception units.
// Revision: 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  // REGIMM rt field (instr[20:16])
  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;

  // SPECIAL funct field (instr[5:0])
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  // Exception code meaning "no exception"
  localparam int EXC_NONE = 0;

  // True for every instruction that owns a delay slot.
  function automatic logic is_branch(input logic [31:0] instr);
    logic [5:0] op;
    logic [4:0] rt;
    logic [5:0] fn;
    op = instr[31:26];
    rt = instr[20:16];
    fn = instr[5:0];
    is_branch = 1'b0;
    case (op)
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_J, OP_JAL: is_branch = 1'b1;
      OP_REGIMM:  is_branch = (rt == RT_BLTZ) || (rt == RT_BGEZ);
      OP_SPECIAL: is_branch = (fn == FN_JR) || (fn == FN_JALR);
      default:    is_branch = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fq_ring.sv
`default_nettype none
// ============================================================================
// fq_ring
// ----------------------------------------------------------------------------
// DEPTH-entry ring buffer: storage array, head/tail pointers, occupancy count
// and full/empty flags. DEPTH need not be a power of two; pointers wrap by
// explicit compare.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   flush            empties the ring; a push/pop in the same cycle is lost
//   push, pop        write at tail / advance head (caller guarantees legality:
//                    no push when full unless popping, no pop when empty)
//   wdata            entry written on push
//   rdata            head entry (registered storage, no bypass from wdata)
//   full, empty      occupancy flags
// Revision: 1.0 - initial release
// ============================================================================
module fq_ring #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) next_ptr = '0;
    else                        next_ptr = p + 1'b1;
  endfunction

  assign do_push = push && !reset && !flush;
  assign do_pop  = pop  && !reset && !flush;

  // Storage carries no reset; validity is tracked solely by count.
  // When full and popping, tail == head: the write lands on the slot being
  // read this cycle, which is safe because the read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= next_ptr(tail);
      if (do_pop)  head <= next_ptr(head);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  assign rdata = mem[head];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue
// ----------------------------------------------------------------------------
// Fetch-to-decode buffer: DEPTH-entry ring with valid/ready handshake on both
// sides, carrying PC, instruction, fetch exception code and branch-delay
// status into decode. flush drops every entry in one cycle.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   flush                      drop all entries (exception entry, eret)
//   in_valid / in_ready        fetch handshake; in_ready also asserts on a
//                              full queue when decode consumes this cycle
//   in_pc, in_instr, in_exc    fetched entry (in_exc = 0 means no exception)
//   out_valid / out_ready      decode handshake
//   out_instr                  head instruction, 0 when exception-tagged
//   out_pc, out_pc4, out_pc8   head PC and PC+4 / PC+8 (RESET_PC when empty)
//   out_exc                    head exception code
//   out_bd                     head is the delay slot of the last consumed op
// Revision: 1.0 - initial release
// ============================================================================
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter int              XLEN     = 32,   // must be >= 32
  parameter int              EXC_W    = 5,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_instr,
  input  logic [EXC_W-1:0] in_exc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_pc4,
  output logic [XLEN-1:0]  out_pc8,
  output logic [EXC_W-1:0] out_exc,
  output logic             out_bd
);

  localparam int ENTRY_W = 2 * XLEN + EXC_W;

  logic [XLEN-1:0]    store_instr;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] rdata;
  logic [XLEN-1:0]    head_pc;
  logic [XLEN-1:0]    head_instr;
  logic [EXC_W-1:0]   head_exc;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               bd_flag;

  // A faulting fetch never delivers its word to decode.
  assign store_instr = (in_exc == EXC_W'(EXC_NONE)) ? in_instr : '0;
  assign wdata       = {in_pc, store_instr, in_exc};
  assign {head_pc, head_instr, head_exc} = rdata;

  // The only combinational input-to-output path: out_ready -> in_ready.
  assign in_ready  = !full || out_ready;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  fq_ring #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ring (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  // Remembers whether the instruction just handed to decode owns a delay
  // slot; the next head is then that slot.
  always_ff @(posedge clk) begin
    if (reset || flush) bd_flag <= 1'b0;
    else if (pop)       bd_flag <= is_branch(head_instr[31:0]);
  end

  assign out_instr = out_valid ? head_instr : '0;
  assign out_exc   = out_valid ? head_exc   : '0;
  assign out_pc    = out_valid ? head_pc    : RESET_PC;
  assign out_pc4   = out_pc + XLEN'(4);
  assign out_pc8   = out_pc + XLEN'(8);
  assign out_bd    = bd_flag && out_valid;

endmodule
`default_nettype wire
